load_store_unit: RTL and testbench

//  Sits directly upstream of MainMemory; CPU memory stage issues byte/half/word loads and stores here.

---
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide MainMemory: byte/half/word access, read-modify-write for sub-word stores.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests complete immediately with err and no memory access.
module load_store_unit #(
  parameter int WORD_ADDR = 1,
  parameter int DW        = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          ld_signed,
  input  logic [31:0]   addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [31:0]   mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state, state_next;
  logic [1:0]    lane_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [15:0]   wdata_q;
  logic          err_q;
  logic          misaligned;
  logic [31:0]   mapped_addr;
  logic [DW-1:0] shifted;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_val;
  logic [DW-1:0] lane_mask;
  logic [DW-1:0] lane_data;
  logic [DW-1:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign mapped_addr = (WORD_ADDR != 0) ? {2'b00, addr[31:2]} : {addr[31:2], 2'b00};

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = done & err_q;
  assign mem_write = (state == WRITE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned)           state_next = DONE;
          else if (we && size[1])   state_next = WRITE;
          else                      state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction for loads and lane replacement for the read-modify-write merge.
  always_comb begin
    shifted  = mem_rdata >> {lane_q, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00FF << {lane_q, 3'b000};
      lane_data = {4{wdata_q[7:0]}};
    end else begin
      lane_mask = lane_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      lane_data = {2{wdata_q}};
    end
    merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lane_q    <= 2'b00;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req) begin
            lane_q   <= addr[1:0];
            we_q     <= we;
            size_q   <= size;
            signed_q <= ld_signed;
            wdata_q  <= wdata[15:0];
            err_q    <= misaligned;
            if (!misaligned) mem_addr <= mapped_addr;
            if (we && size[1]) mem_wdata <= wdata;
          end
        end
        READ: begin
          if (we_q) mem_wdata <= merged;
          else      rdata     <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: behavioural byte-lane model, directed cases then random traffic.
// Honours LSU_MISALIGN_TRAP_EN in its model when the build defines it.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, we, ld_signed;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, err, mem_write;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    int          start;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram[64];
  logic [31:0] ref_mem[64];
  logic [31:0] last_rdata;
  bit          ram_ready = 1'b0;
  int          cycle = 0;
  int          wr_cnt = 0;
  int          wr_base = 0;
  int          checks = 0;
  int          fails = 0;

  load_store_unit #(.WORD_ADDR(1), .DW(32)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .ld_signed(ld_signed), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .err(err), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // MainMemory stand-in: combinational read, commit on the low phase of a write cycle.
  assign mem_rdata = ram[mem_addr[5:0]];
  always @(negedge clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;
      ram_ready = 1'b1;
    end else if (mem_write) begin
      ram[mem_addr[5:0]] = mem_wdata;
    end
  end

  always @(posedge clock) cycle <= cycle + 1;
  always @(negedge clock) if (mem_write) wr_cnt++;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        e = sb.pop_front();
        check_output("rdata", rdata, e.rdata);
        check_output("err", {31'b0, err}, {31'b0, e.err});
        check_output("latency", 32'(cycle - e.start), 32'(e.lat));
        check_output("write_cycles", 32'(wr_cnt - wr_base), 32'(e.writes));
        wr_base = wr_cnt;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      checks++;
      fails++;
      $display("[TB] FAIL idle_timeout: got busy=1 expected idle within 50 cycles");
    end
  endtask

  // Reference model works on byte lanes of a word array with plain shifts and masks.
  task automatic apply_stimulus(input logic st, input logic [1:0] sz, input logic sgn,
                                input logic [31:0] a, input logic [31:0] d,
                                input bit keep, input bit track);
    exp_t        e;
    logic [31:0] w, v, b;
    int          sh;
    bit          mis;
    wait_idle();
    we = st; size = sz; ld_signed = sgn; addr = a; wdata = d; req = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((sz == 2'b01) && (a % 2 != 0)) || ((sz >= 2'b10) && (a % 4 != 0));
`else
    mis = 1'b0;
`endif
    w = ref_mem[a[7:2]];
    e.start = cycle;
    e.err = 1'b0;
    e.writes = 0;
    if (mis) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (st) begin
      e.writes = 1;
      e.lat = 3;
      if (sz == 2'b00) begin
        sh = 8 * (a % 4);
        w = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end else if (sz == 2'b01) begin
        sh = 16 * ((a / 2) % 2);
        w = (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end else begin
        w = d;
        e.lat = 2;
      end
      if (track) ref_mem[a[7:2]] = w;
    end else begin
      e.lat = 2;
      if (sz == 2'b00) begin
        b = (w >> (8 * (a % 4))) & 32'hFF;
        v = (sgn && b[7]) ? (b | 32'hFFFF_FF00) : b;
      end else if (sz == 2'b01) begin
        b = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        v = (sgn && b[15]) ? (b | 32'hFFFF_0000) : b;
      end else begin
        v = w;
      end
      if (track) last_rdata = v;
    end
    e.rdata = last_rdata;
    if (track) sb.push_back(e);
    @(negedge clock);
    if (!keep) req = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; ld_signed = 1'b0;
    addr = '0; wdata = '0; last_rdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    repeat (2) @(negedge clock);
    check_output("reset_busy", {31'b0, busy}, 32'h0);
    check_output("reset_done", {31'b0, done}, 32'h0);
    check_output("reset_err", {31'b0, err}, 32'h0);
    check_output("reset_rdata", rdata, 32'h0);
    check_output("reset_mem_write", {31'b0, mem_write}, 32'h0);
    check_output("reset_mem_addr", mem_addr, 32'h0);
    check_output("reset_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    apply_stimulus(1'b1, 2'b10, 1'b0, 32'd20, 32'hABCD_1234, 0, 1);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, 0, 1);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'd20, 32'h1122_3344, 0, 1);
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'd22, 32'h0000_00AA, 0, 1);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, 0, 1);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'd20, 32'h80FF_7F01, 0, 1);
    apply_stimulus(1'b0, 2'b00, 1'b1, 32'd21, 32'h0, 0, 1);
    apply_stimulus(1'b0, 2'b00, 1'b1, 32'd22, 32'h0, 0, 1);
    apply_stimulus(1'b0, 2'b01, 1'b0, 32'd22, 32'h0, 0, 1);
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'd40, 32'h5555_BEEF, 1, 1);
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'd43, 32'h0000_0012, 0, 1);
    apply_stimulus(1'b0, 2'b11, 1'b1, 32'd40, 32'h0, 0, 1);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'd21, 32'hCAFE_F00D, 0, 1);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, 0, 1);

    // Abort a sub-word store while it is reading; the word must survive untouched.
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'd22, 32'h0000_0077, 0, 0);
    check_output("abort_in_read_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check_output("abort_busy", {31'b0, busy}, 32'h0);
    check_output("abort_mem_write", {31'b0, mem_write}, 32'h0);
    check_output("abort_rdata", rdata, 32'h0);
    check_output("abort_mem_addr", mem_addr, 32'h0);
    check_output("abort_mem_wdata", mem_wdata, 32'h0);
    last_rdata = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_output("abort_mem_word", ram[5], ref_mem[5]);

    for (int i = 0; i < 80; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 255)), $urandom, 0, 1);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clock);
    for (int i = 0; i < 64; i++) check_output("final_mem", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
